// File: rtl/dram_arb_pkg.sv
// Shared types for the two-port DRAM arbiter: FSM states and the latched request word.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
  } req_t;

  // Bit 0 of the byte enables doubles as the read/write selector.
  function automatic logic is_write(input req_t r);
    return r.we[0];
  endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Requester-side and DRAM-wrapper-side bundles for the arbiter.
interface dram_req_if;
  logic        oe;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic        valid;
  logic        wack;
  logic        busy;

  modport master (output oe, addr, wdata, we, input rdata, valid, wack, busy);
  modport slave  (input oe, addr, wdata, we, output rdata, valid, wack, busy);
endinterface

interface dram_mem_if;
  logic        oe;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata;
  logic        valid;
  logic        busy;

  modport master (output oe, addr, wdata, we, input rdata, valid, busy);
  modport slave  (input oe, addr, wdata, we, output rdata, valid, busy);
endinterface

// File: rtl/dram_arb_port.sv
// One requester slot: captures a request pulse, holds it until granted, and
// registers the completion pulse and read data returned to that requester.
module dram_arb_port
  import dram_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  dram_req_if.slave   req,
  input  logic        i_grant,
  input  logic        i_inflight,
  input  logic        i_done_rd,
  input  logic        i_done_wr,
  input  logic [31:0] i_done_data,
  output logic        o_pend,
  output req_t        o_req
);

  logic        r_pend;
  req_t        r_req;
  logic [31:0] r_rdata;
  logic        r_valid;
  logic        r_wack;
  logic        w_busy;

  assign w_busy = r_pend | i_inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= 1'b0;
      r_req   <= '0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_wack  <= 1'b0;
    end else begin
      r_valid <= i_done_rd;
      r_wack  <= i_done_wr;
      if (i_done_rd) begin
        r_rdata <= i_done_data;
      end
      // Grant and capture never coincide: a pending slot reports busy.
      if (i_grant) begin
        r_pend <= 1'b0;
      end else if (req.oe && !w_busy) begin
        r_pend      <= 1'b1;
        r_req.addr  <= req.addr;
        r_req.wdata <= req.wdata;
        r_req.we    <= req.we;
      end
    end
  end

  assign o_pend    = r_pend;
  assign o_req     = r_req;
  assign req.busy  = w_busy;
  assign req.rdata = r_rdata;
  assign req.valid = r_valid;
  assign req.wack  = r_wack;

endmodule

// File: rtl/dram_arbiter.sv
// Shares one DRAM wrapper port between instruction fetch (p0) and load/store (p1),
// one command in flight, completions routed to the owner, optional WAIT timeout.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter bit          RR     = 1'b1,
  parameter int unsigned TO_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        calib_done,
  dram_req_if.slave   p0,
  dram_req_if.slave   p1,
  dram_mem_if.master  dram,
  output logic        timeout
);

  localparam bit          TO_EN   = (TO_CYC != 0);
  localparam logic [31:0] TO_LAST = 32'(TO_CYC - 1);

  state_t      r_state;
  logic        r_owner;
  logic        r_rr_last;
  logic        r_dram_oe;
  logic        r_timeout;
  req_t        r_cmd;
  logic [31:0] r_wcnt;
  logic [31:0] r_rd_cap;

  logic        w_pend0, w_pend1;
  req_t        w_req0, w_req1;
  req_t        w_sel, w_cmd;
  logic        w_pick, w_issue, w_complete, w_abort, w_wr;
  logic [31:0] w_cmp_data;

  always_comb begin
    w_pick = w_pend1;
    if (w_pend0 && w_pend1) begin
      w_pick = RR ? ~r_rr_last : 1'b1;
    end
    w_sel = w_pick ? w_req1 : w_req0;
    w_cmd = w_sel;
    if (!is_write(w_sel)) begin
      w_cmd.we = 4'h0;
    end
  end

  assign w_issue    = (r_state == IDLE) && calib_done && !dram.busy && (w_pend0 || w_pend1);
  assign w_wr       = is_write(r_cmd);
  assign w_complete = (r_state == WAIT) && !dram.busy;
  assign w_abort    = TO_EN && (r_state == WAIT) && dram.busy && (r_wcnt == TO_LAST);
  // The read beat may land before or together with busy falling.
  assign w_cmp_data = dram.valid ? dram.rdata : r_rd_cap;

  dram_arb_port u_p0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (p0),
    .i_grant     (w_issue && !w_pick),
    .i_inflight  ((r_state != IDLE) && !r_owner),
    .i_done_rd   (w_complete && !w_wr && !r_owner),
    .i_done_wr   (w_complete && w_wr && !r_owner),
    .i_done_data (w_cmp_data),
    .o_pend      (w_pend0),
    .o_req       (w_req0)
  );

  dram_arb_port u_p1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (p1),
    .i_grant     (w_issue && w_pick),
    .i_inflight  ((r_state != IDLE) && r_owner),
    .i_done_rd   (w_complete && !w_wr && r_owner),
    .i_done_wr   (w_complete && w_wr && r_owner),
    .i_done_data (w_cmp_data),
    .o_pend      (w_pend1),
    .o_req       (w_req1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_dram_oe <= 1'b0;
      r_timeout <= 1'b0;
      r_cmd     <= '0;
      r_wcnt    <= '0;
      r_rd_cap  <= '0;
    end else begin
      r_dram_oe <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_dram_oe <= 1'b1;
            r_cmd     <= w_cmd;
            r_owner   <= w_pick;
            r_rr_last <= w_pick;
            r_state   <= LAUNCH;
          end
        end
        // Wrapper raises busy one cycle after the strobe; don't look at it yet.
        LAUNCH: begin
          r_wcnt   <= '0;
          r_rd_cap <= '0;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (dram.valid && !w_wr) begin
            r_rd_cap <= dram.rdata;
          end
          if (w_complete) begin
            r_state <= IDLE;
          end else if (w_abort) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_wcnt <= r_wcnt + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dram.oe    = r_dram_oe;
  assign dram.addr  = r_cmd.addr;
  assign dram.wdata = r_cmd.wdata;
  assign dram.we    = r_cmd.we;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: behavioural DRAM wrapper, command and response scoreboards.
module tb_dram_arbiter;
  import dram_arb_pkg::*;

  localparam int LAT = 4;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic calib_done;
  logic timeout;
  bit   stuck;

  always #5 clk = ~clk;

  dram_req_if p0_if ();
  dram_req_if p1_if ();
  dram_mem_if mem_if ();

  dram_arbiter #(.RR(1'b1), .TO_CYC(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .calib_done (calib_done),
    .p0         (p0_if),
    .p1         (p1_if),
    .dram       (mem_if),
    .timeout    (timeout)
  );

  req_t        cmd_q[$];
  resp_t       resp_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_cmd = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_cmd(input int port, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] we, input bit with_resp, input logic [31:0] rd);
    req_t c;
    resp_t r;
    c.addr  = a;
    c.wdata = d;
    c.we    = we[0] ? we : 4'h0;
    cmd_q.push_back(c);
    if (with_resp) begin
      r.port = port;
      r.wr   = we[0];
      r.data = rd;
      resp_q.push_back(r);
    end
  endtask

  task automatic set_req(input int port, input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    if (port == 0) begin
      p0_if.oe = 1'b1; p0_if.addr = a; p0_if.wdata = d; p0_if.we = we;
    end else begin
      p1_if.oe = 1'b1; p1_if.addr = a; p1_if.wdata = d; p1_if.we = we;
    end
  endtask

  task automatic tick_clear();
    @(negedge clk);
    p0_if.oe = 1'b0;
    p1_if.oe = 1'b0;
  endtask

  // Behavioural wrapper: busy for LAT cycles after a strobe; read data with the busy fall.
  task automatic wrapper_loop();
    int          cnt = 0;
    bit          cur_wr = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] word;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h104] = 32'h0BADF00D;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        mem[32'h300 + 32'(p * 16 + k * 4)] = (32'h300 + 32'(p * 16 + k * 4)) ^ 32'h5A5A0000;
      end
    end
    mem[32'h400] = 32'h04001234;
    mem[32'h504] = 32'h0504ABCD;
    mem[32'h600] = 32'h06000000;
    mem[32'h604] = 32'h06045678;
    forever begin
      @(negedge clk);
      mem_if.valid = 1'b0;
      if (mem_if.oe) begin
        mem_if.busy = 1'b1;
        cnt         = LAT;
        cur_addr    = mem_if.addr;
        cur_wr      = mem_if.we[0];
        if (cur_wr) begin
          word = mem.exists(cur_addr) ? mem[cur_addr] : 32'h0;
          for (int b = 0; b < 4; b++) begin
            if (mem_if.we[b]) word[b*8 +: 8] = mem_if.wdata[b*8 +: 8];
          end
          mem[cur_addr] = word;
        end
      end else if (mem_if.busy && !stuck) begin
        cnt--;
        if (cnt == 0) begin
          mem_if.busy  = 1'b0;
          mem_if.valid = 1'b1;
          // A stray beat on writes must not reach the requester.
          mem_if.rdata = cur_wr ? 32'hBAD0BAD0 :
                         (mem.exists(cur_addr) ? mem[cur_addr] : 32'hFFFFFFFF);
        end
      end
    end
  endtask

  task automatic mon_resp(input int port, input logic valid, input logic wack, input logic [31:0] rdata);
    resp_t r;
    if (valid || wack) begin
      if (resp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp port=%0d valid=%0b wack=%0b required=none", port, valid, wack);
      end else begin
        r = resp_q.pop_front();
        chk("resp_port", 64'(port), 64'(r.port));
        chk("resp_is_wack", 64'(wack), 64'(r.wr));
        chk("resp_valid_wack_onehot", 64'(valid & wack), 64'h0);
        if (!r.wr) chk("resp_rdata", 64'(rdata), 64'(r.data));
      end
    end
  endtask

  task automatic monitor_loop();
    req_t c;
    forever begin
      @(negedge clk);
      if (mem_if.oe) begin
        n_cmd++;
        if (cmd_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_cmd addr=%0h required=none", mem_if.addr);
        end else begin
          c = cmd_q.pop_front();
          chk("cmd_addr", 64'(mem_if.addr), 64'(c.addr));
          chk("cmd_wdata", 64'(mem_if.wdata), 64'(c.wdata));
          chk("cmd_we", 64'(mem_if.we), 64'(c.we));
        end
      end
      mon_resp(0, p0_if.valid, p0_if.wack, p0_if.rdata);
      mon_resp(1, p1_if.valid, p1_if.wack, p1_if.rdata);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((resp_q.size() != 0 || cmd_q.size() != 0 || p0_if.busy || p1_if.busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle_in_budget", 64'(k < 300), 64'h1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_oe();
    int k = 0;
    while (!mem_if.oe && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("dram_oe_seen", 64'(mem_if.oe), 64'h1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cyc;
    rst_n = 1'b0;
    calib_done = 1'b0;
    stuck = 1'b0;
    p0_if.oe = 1'b0; p0_if.addr = '0; p0_if.wdata = '0; p0_if.we = '0;
    p1_if.oe = 1'b0; p1_if.addr = '0; p1_if.wdata = '0; p1_if.we = '0;
    mem_if.busy = 1'b0; mem_if.valid = 1'b0; mem_if.rdata = '0;
    fork
      wrapper_loop();
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    #1;
    chk("rst_dram_oe", 64'(mem_if.oe), 64'h0);
    chk("rst_dram_addr", 64'(mem_if.addr), 64'h0);
    chk("rst_p0_busy", 64'(p0_if.busy), 64'h0);
    chk("rst_p1_valid", 64'(p1_if.valid), 64'h0);
    chk("rst_timeout", 64'(timeout), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: held off until calibration, then a plain read
    @(negedge clk);
    set_req(0, 32'h100, 32'h0, 4'h0);
    expect_cmd(0, 32'h100, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
    tick_clear();
    repeat (6) @(negedge clk);
    #1;
    chk("calib_low_no_cmd", 64'(n_cmd), 64'h0);
    chk("calib_low_p0_busy", 64'(p0_if.busy), 64'h1);
    calib_done = 1'b1;
    wait_idle();
    chk("p0_rdata_held", 64'(p0_if.rdata), 64'hDEADBEEF);

    // 2: simultaneous read/write, p0 first after reset, write acked to p1 only
    reset_dut();
    @(negedge clk);
    set_req(0, 32'h104, 32'h0, 4'h0);
    set_req(1, 32'h200, 32'h11223344, 4'hF);
    expect_cmd(0, 32'h104, 32'h0, 4'h0, 1'b1, 32'h0BADF00D);
    expect_cmd(1, 32'h200, 32'h11223344, 4'hF, 1'b1, 32'h0);
    tick_clear();
    wait_idle();
    chk("p1_rdata_untouched_by_write", 64'(p1_if.rdata), 64'h0);
    @(negedge clk);
    set_req(1, 32'h200, 32'h0, 4'h0);
    expect_cmd(1, 32'h200, 32'h0, 4'h0, 1'b1, 32'h11223344);
    tick_clear();
    wait_idle();

    // 3: both ports back-to-back, grants alternate starting with p0
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        expect_cmd(p, 32'h300 + 32'(p * 16 + k * 4), 32'h0, 4'h0, 1'b1,
                   (32'h300 + 32'(p * 16 + k * 4)) ^ 32'h5A5A0000);
      end
    end
    @(negedge clk);
    fork
      begin : req_p0
        for (int k = 0; k < 3; k++) begin
          int w0 = 0;
          while (p0_if.busy && w0 < 100) begin @(negedge clk); w0++; end
          set_req(0, 32'h300 + 32'(k * 4), 32'h0, 4'h0);
          @(negedge clk);
          p0_if.oe = 1'b0;
        end
      end
      begin : req_p1
        for (int k = 0; k < 3; k++) begin
          int w1 = 0;
          while (p1_if.busy && w1 < 100) begin @(negedge clk); w1++; end
          set_req(1, 32'h310 + 32'(k * 4), 32'h0, 4'h0);
          @(negedge clk);
          p1_if.oe = 1'b0;
        end
      end
    join
    wait_idle();

    // 4: second pulse while busy is dropped; read enables stripped on the DRAM side
    #1;
    base = n_cmd;
    @(negedge clk);
    set_req(1, 32'h400, 32'hCAFE0000, 4'hE);
    expect_cmd(1, 32'h400, 32'hCAFE0000, 4'hE, 1'b1, 32'h04001234);
    tick_clear();
    chk("p1_busy_after_capture", 64'(p1_if.busy), 64'h1);
    set_req(1, 32'h404, 32'h0, 4'h0);
    tick_clear();
    wait_idle();
    #1;
    chk("dropped_req_one_cmd", 64'(n_cmd - base), 64'h1);

    // 5: wrapper hangs; abort after 16 WAIT cycles, next issue waits for busy
    stuck = 1'b1;
    @(negedge clk);
    set_req(0, 32'h500, 32'h0, 4'h0);
    expect_cmd(0, 32'h500, 32'h0, 4'h0, 1'b0, 32'h0);
    tick_clear();
    wait_oe();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!timeout && cyc < 100);
    chk("timeout_latency", 64'(cyc), 64'd17);
    chk("timeout_p0_busy", 64'(p0_if.busy), 64'h0);
    @(negedge clk);
    chk("timeout_one_cycle", 64'(timeout), 64'h0);
    #1;
    base = n_cmd;
    set_req(1, 32'h504, 32'h0, 4'h0);
    expect_cmd(1, 32'h504, 32'h0, 4'h0, 1'b1, 32'h0504ABCD);
    tick_clear();
    repeat (10) @(negedge clk);
    #1;
    chk("no_issue_while_busy", 64'(n_cmd - base), 64'h0);
    chk("p1_held_pending", 64'(p1_if.busy), 64'h1);
    stuck = 1'b0;
    wait_idle();

    // 6: reset in WAIT clears everything asynchronously
    @(negedge clk);
    set_req(0, 32'h600, 32'h0, 4'h0);
    expect_cmd(0, 32'h600, 32'h0, 4'h0, 1'b0, 32'h0);
    tick_clear();
    wait_oe();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dram_oe", 64'(mem_if.oe), 64'h0);
    chk("arst_dram_addr", 64'(mem_if.addr), 64'h0);
    chk("arst_dram_we", 64'(mem_if.we), 64'h0);
    chk("arst_p0_busy", 64'(p0_if.busy), 64'h0);
    chk("arst_p0_rdata", 64'(p0_if.rdata), 64'h0);
    chk("arst_p1_rdata", 64'(p1_if.rdata), 64'h0);
    chk("arst_timeout", 64'(timeout), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 32'h604, 32'h0, 4'h0);
    expect_cmd(0, 32'h604, 32'h0, 4'h0, 1'b1, 32'h06045678);
    tick_clear();
    wait_idle();

    chk("cmd_queue_drained", 64'(cmd_q.size()), 64'h0);
    chk("resp_queue_drained", 64'(resp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
